// File: rtl/vdic_rx_pkg.sv
// Shared types and defaults for the vdic_dut_2022 result deserializer.
// Optional feature macro: VDIC_RX_ERR_CNT_EN (adds err_count output on the top).
package vdic_rx_pkg;

  localparam int DATA_PKTS_DEF     = 4;
  localparam int STALL_TIMEOUT_DEF = 16;

  localparam logic PKT_DATA   = 1'b0;
  localparam logic PKT_STATUS = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    TYPE,
    PAYLOAD,
    STOP
  } pkt_state_t;

  typedef enum logic {
    COLLECT,
    WAIT_STATUS
  } word_state_t;

  typedef enum logic [1:0] {
    ERR_STOP,
    ERR_ORDER,
    ERR_STALL,
    ERR_OVERRUN
  } err_cause_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vdic_rx_packet_deser.sv
// Bit-level packet receiver: start/type/8 payload bits/stop, plus a stall timer
// that aborts a packet when serial_valid stays low too long.
module vdic_rx_packet_deser
  import vdic_rx_pkg::*;
#(
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       serial_valid,
  output logic       pkt_done,
  output logic       pkt_type,
  output logic [7:0] pkt_byte,
  output logic       pkt_err
);

  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);
  localparam logic [STALL_W-1:0] STALL_SAT  = STALL_W'(STALL_TIMEOUT);

  pkt_state_t         state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               type_q, type_d;
  logic [7:0]         byte_q, byte_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      type_q      <= 1'b0;
      byte_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      type_q      <= type_d;
      byte_q      <= byte_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    type_d      = type_q;
    byte_d      = byte_q;
    stall_cnt_d = stall_cnt_q;
    pkt_done    = 1'b0;
    pkt_err     = 1'b0;

    if (serial_valid) begin
      stall_cnt_d = '0;
    end else if (state_q != IDLE && stall_cnt_q != STALL_SAT) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // The idle line never times out; only a started packet can stall.
    if (!serial_valid && state_q != IDLE && stall_cnt_q == STALL_LAST) begin
      pkt_err     = 1'b1;
      state_d     = IDLE;
      stall_cnt_d = '0;
    end else if (serial_valid) begin
      case (state_q)
        IDLE: begin
          if (!serial_in) state_d = TYPE;
        end
        TYPE: begin
          type_d    = serial_in;
          bit_cnt_d = 3'd7;
          state_d   = PAYLOAD;
        end
        PAYLOAD: begin
          byte_d = {byte_q[6:0], serial_in};
          if (bit_cnt_q == 3'd0) state_d = STOP;
          else bit_cnt_d = bit_cnt_q - 3'd1;
        end
        STOP: begin
          state_d = IDLE;
          if (serial_in) pkt_done = 1'b1;
          else pkt_err = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pkt_type = type_q;
  assign pkt_byte = byte_q;

endmodule

// File: rtl/vdic_result_deser.sv
// Assembles DATA_PKTS data packets plus one status packet into a result word
// presented on a valid/ready port. Optional macro: VDIC_RX_ERR_CNT_EN (err_count).
module vdic_result_deser
  import vdic_rx_pkg::*;
#(
  parameter int DATA_PKTS     = DATA_PKTS_DEF,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   serial_in,
  input  logic                   serial_valid,
  output logic [8*DATA_PKTS-1:0] result_data,
  output logic [7:0]             result_status,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   frame_err
`ifdef VDIC_RX_ERR_CNT_EN
  ,
  output logic [15:0]            err_count
`endif
);

  localparam int ACC_W = 8 * DATA_PKTS;
  localparam int CNT_W = $clog2(DATA_PKTS + 1);
  localparam logic [CNT_W-1:0] LAST_PKT = CNT_W'(DATA_PKTS - 1);

  logic       pkt_done;
  logic       pkt_type;
  logic [7:0] pkt_byte;
  logic       pkt_err;

  vdic_rx_packet_deser #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_packet (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .serial_valid(serial_valid),
    .pkt_done    (pkt_done),
    .pkt_type    (pkt_type),
    .pkt_byte    (pkt_byte),
    .pkt_err     (pkt_err)
  );

  word_state_t      word_q, word_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_data_q, result_data_d;
  logic [7:0]       result_status_q, result_status_d;
  logic             result_valid_q, result_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q          <= COLLECT;
      pkt_cnt_q       <= '0;
      acc_q           <= '0;
      result_data_q   <= '0;
      result_status_q <= '0;
      result_valid_q  <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      word_q          <= word_d;
      pkt_cnt_q       <= pkt_cnt_d;
      acc_q           <= acc_d;
      result_data_q   <= result_data_d;
      result_status_q <= result_status_d;
      result_valid_q  <= result_valid_d;
      frame_err_q     <= frame_err_d;
    end
  end

  always_comb begin
    word_d          = word_q;
    pkt_cnt_d       = pkt_cnt_q;
    acc_d           = acc_q;
    result_data_d   = result_data_q;
    result_status_d = result_status_q;
    result_valid_d  = result_valid_q;
    frame_err_d     = 1'b0;

    if (result_valid_q && result_ready) result_valid_d = 1'b0;

    if (pkt_err) begin
      frame_err_d = 1'b1;
    end else if (pkt_done) begin
      case (word_q)
        COLLECT: begin
          if (pkt_type == PKT_DATA) begin
            acc_d = (acc_q << 8) | ACC_W'(pkt_byte);
            if (pkt_cnt_q == LAST_PKT) begin
              word_d    = WAIT_STATUS;
              pkt_cnt_d = '0;
            end else begin
              pkt_cnt_d = pkt_cnt_q + 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        WAIT_STATUS: begin
          // A pending result that is not being taken this cycle wins over the new one.
          if (pkt_type != PKT_STATUS) begin
            frame_err_d = 1'b1;
          end else if (result_valid_q && !result_ready) begin
            frame_err_d = 1'b1;
          end else begin
            result_data_d   = acc_q;
            result_status_d = pkt_byte;
            result_valid_d  = 1'b1;
            word_d          = COLLECT;
            pkt_cnt_d       = '0;
            acc_d           = '0;
          end
        end
        default: frame_err_d = 1'b1;
      endcase
    end

    if (frame_err_d) begin
      word_d    = COLLECT;
      pkt_cnt_d = '0;
      acc_d     = '0;
    end
  end

  assign result_data   = result_data_q;
  assign result_status = result_status_q;
  assign result_valid  = result_valid_q;
  assign frame_err     = frame_err_q;

`ifdef VDIC_RX_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (frame_err_d) err_count_d = sat_inc16(err_count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= '0;
    else err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_vdic_result_deser.sv
// Directed + randomized bench for vdic_result_deser with a frame-level reference
// model (expected results are bytes concatenated first-MSB).
module tb_vdic_result_deser;
  import vdic_rx_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        serial_in;
  logic        serial_valid;
  logic [31:0] result_data;
  logic [7:0]  result_status;
  logic        result_valid;
  logic        result_ready;
  logic        frame_err;
`ifdef VDIC_RX_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int exp_errs = 0;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];

  vdic_result_deser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .result_data  (result_data),
    .result_status(result_status),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .frame_err    (frame_err)
`ifdef VDIC_RX_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every accepted result and every error pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) got_q.push_back({result_data, result_status});
    if (frame_err) err_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendBit(input logic b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
    repeat (g) tick();
    serial_valid = 1'b1;
    serial_in    = b;
    tick();
    serial_valid = 1'b0;
    serial_in    = 1'b1;
  endtask

  task automatic applyStimulus(input logic kind, input logic [7:0] b, input int gap,
                               input logic stop_bit, input logic raise_ready);
    sendBit(1'b0, gap);
    sendBit(kind, gap);
    for (int i = 7; i >= 0; i--) sendBit(b[i], gap);
    if (raise_ready) result_ready = 1'b1;
    sendBit(stop_bit, gap);
  endtask

  task automatic sendFrame(input logic [31:0] d, input logic [7:0] s, input int gap, input logic raise_ready);
    for (int i = 3; i >= 0; i--) applyStimulus(PKT_DATA, d[8*i +: 8], gap, 1'b1, 1'b0);
    applyStimulus(PKT_STATUS, s, gap, 1'b1, raise_ready);
  endtask

  task automatic checkResult(input string tag, input logic [31:0] d, input logic [7:0] s);
    checkOutput({tag, "_valid"}, 40'(result_valid), 40'd1);
    checkOutput({tag, "_data"}, 40'(result_data), 40'(d));
    checkOutput({tag, "_status"}, 40'(result_status), 40'(s));
    checkOutput({tag, "_noerr"}, 40'(frame_err), 40'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  s;
    logic [7:0]  bytes[4];
    logic [31:0] model;

    rst_n        = 1'b1;
    serial_in    = 1'b1;
    serial_valid = 1'b0;
    result_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_valid", 40'(result_valid), 40'd0);
    checkOutput("reset_data", 40'(result_data), 40'd0);
    checkOutput("reset_status", 40'(result_status), 40'd0);
    checkOutput("reset_err", 40'(frame_err), 40'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] basic frame");
    applyStimulus(PKT_DATA, 8'h12, 0, 1'b1, 1'b0);
    applyStimulus(PKT_DATA, 8'h34, 0, 1'b1, 1'b0);
    applyStimulus(PKT_DATA, 8'h56, 0, 1'b1, 1'b0);
    applyStimulus(PKT_DATA, 8'h78, 0, 1'b1, 1'b0);
    checkOutput("t1_not_yet", 40'(result_valid), 40'd0);
    applyStimulus(PKT_STATUS, 8'h01, 0, 1'b1, 1'b0);
    checkResult("t1", 32'h12345678, 8'h01);
    exp_q.push_back({32'h12345678, 8'h01});
    tick();
    checkOutput("t1_consumed", 40'(result_valid), 40'd0);

    $display("[TB] toggling serial_valid");
    sendFrame(32'h12345678, 8'h01, 1, 1'b0);
    checkResult("t2", 32'h12345678, 8'h01);
    exp_q.push_back({32'h12345678, 8'h01});
    tick();

    $display("[TB] bad stop bit");
    applyStimulus(PKT_DATA, 8'hAA, 0, 1'b0, 1'b0);
    exp_errs++;
    checkOutput("t3_err", 40'(frame_err), 40'd1);
    checkOutput("t3_novalid", 40'(result_valid), 40'd0);
    tick();
    checkOutput("t3_pulse_end", 40'(frame_err), 40'd0);
    d = $urandom;
    s = 8'($urandom_range(255, 0));
    sendFrame(d, s, 0, 1'b0);
    checkResult("t3_recover", d, s);
    exp_q.push_back({d, s});
    tick();

    $display("[TB] status too early");
    applyStimulus(PKT_DATA, 8'h11, 0, 1'b1, 1'b0);
    applyStimulus(PKT_DATA, 8'h22, 0, 1'b1, 1'b0);
    applyStimulus(PKT_STATUS, 8'h33, 0, 1'b1, 1'b0);
    exp_errs++;
    checkOutput("t4_err", 40'(frame_err), 40'd1);
    checkOutput("t4_novalid", 40'(result_valid), 40'd0);
    tick();
    sendFrame(32'hDEADBEEF, 8'h00, 0, 1'b0);
    checkResult("t4_recover", 32'hDEADBEEF, 8'h00);
    exp_q.push_back({32'hDEADBEEF, 8'h00});
    tick();

    $display("[TB] overrun");
    result_ready = 1'b0;
    sendFrame(32'hA0A1A2A3, 8'h5A, 0, 1'b0);
    checkResult("t5_a", 32'hA0A1A2A3, 8'h5A);
    sendFrame(32'hB0B1B2B3, 8'hA5, 0, 1'b0);
    exp_errs++;
    checkOutput("t5_err", 40'(frame_err), 40'd1);
    checkOutput("t5_held_valid", 40'(result_valid), 40'd1);
    checkOutput("t5_held_data", 40'(result_data), 40'hA0A1A2A3);
    checkOutput("t5_held_status", 40'(result_status), 40'h5A);
    result_ready = 1'b1;
    exp_q.push_back({32'hA0A1A2A3, 8'h5A});
    tick();
    checkOutput("t5_drained", 40'(result_valid), 40'd0);

    $display("[TB] accept and complete in same cycle");
    result_ready = 1'b0;
    sendFrame(32'hC0C1C2C3, 8'h3C, 0, 1'b0);
    checkResult("t5_c", 32'hC0C1C2C3, 8'h3C);
    sendFrame(32'hD0D1D2D3, 8'hC3, 0, 1'b1);
    checkResult("t5_d", 32'hD0D1D2D3, 8'hC3);
    exp_q.push_back({32'hC0C1C2C3, 8'h3C});
    exp_q.push_back({32'hD0D1D2D3, 8'hC3});
    tick();
    checkOutput("t5_d_drained", 40'(result_valid), 40'd0);

    $display("[TB] stall boundary");
    d = $urandom;
    s = 8'($urandom_range(255, 0));
    sendFrame(d, s, 15, 1'b0);
    checkResult("t6_gap15", d, s);
    exp_q.push_back({d, s});
    tick();
    sendBit(1'b0, 0);
    sendBit(PKT_DATA, 0);
    sendBit(1'b1, 0);
    sendBit(1'b0, 0);
    sendBit(1'b1, 0);
    repeat (15) tick();
    checkOutput("t6_stall15", 40'(frame_err), 40'd0);
    tick();
    exp_errs++;
    checkOutput("t6_stall16", 40'(frame_err), 40'd1);
    tick();
    checkOutput("t6_err_pulses", 40'(err_pulses), 40'(exp_errs));
`ifdef VDIC_RX_ERR_CNT_EN
    checkOutput("t6_err_count", 40'(err_count), 40'(exp_errs));
`endif

    $display("[TB] reset mid-packet");
    result_ready = 1'b0;
    sendFrame(32'h0F1E2D3C, 8'h77, 0, 1'b0);
    checkResult("t6_held", 32'h0F1E2D3C, 8'h77);
    sendBit(1'b0, 0);
    sendBit(PKT_DATA, 0);
    sendBit(1'b1, 0);
    sendBit(1'b1, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 40'(result_valid), 40'd0);
    checkOutput("rst_data", 40'(result_data), 40'd0);
    checkOutput("rst_status", 40'(result_status), 40'd0);
    checkOutput("rst_err", 40'(frame_err), 40'd0);
`ifdef VDIC_RX_ERR_CNT_EN
    checkOutput("rst_err_count", 40'(err_count), 40'd0);
`endif
    tick();
    rst_n = 1'b1;
    result_ready = 1'b1;
    tick();
    sendFrame(32'h89ABCDEF, 8'h42, 0, 1'b0);
    checkResult("after_rst", 32'h89ABCDEF, 8'h42);
    exp_q.push_back({32'h89ABCDEF, 8'h42});
    tick();

    $display("[TB] random frames");
    for (int k = 0; k < 6; k++) begin
      model = 32'd0;
      for (int i = 0; i < 4; i++) begin
        bytes[i] = 8'($urandom_range(255, 0));
        model = model * 32'd256 + 32'(bytes[i]);
      end
      s = 8'($urandom_range(255, 0));
      for (int i = 0; i < 4; i++) applyStimulus(PKT_DATA, bytes[i], -1, 1'b1, 1'b0);
      applyStimulus(PKT_STATUS, s, -1, 1'b1, 1'b0);
      checkResult($sformatf("rand%0d", k), model, s);
      exp_q.push_back({model, s});
      tick();
    end
    repeat (2) tick();

    checkOutput("final_err_pulses", 40'(err_pulses), 40'(exp_errs));
    checkOutput("accepted_count", 40'(got_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput($sformatf("accepted%0d", i), got_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
